// File: rtl/dct_pkg.sv
// Shared types and elaboration-time helpers for the DCT coefficient engine.
// cos_weight is evaluated only at elaboration to fill the cosine ROM.
package dct_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } dct_state_e;

   // Width of a frequency or pixel index for an n x n block.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Separable cosine weight, scaled by 2^frac and truncated toward zero.
   function automatic int cos_weight(input int n, input int frac, input int k1, input int k2,
                                     input int n1, input int n2);
      real pi;
      real scale;
      real c1;
      real c2;
      pi    = 3.14159265358979323846;
      scale = $itor(1 << frac);
      c1    = $cos($itor((2 * n1 + 1) * k1) * pi / $itor(2 * n));
      c2    = $cos($itor((2 * n2 + 1) * k2) * pi / $itor(2 * n));
      return $rtoi(scale * c1 * c2);
   endfunction

endpackage

// File: rtl/dct_coef_engine_if.sv
// Pixel stream in and coefficient stream out of the DCT coefficient engine.
// master is the block-buffer/quantiser side; slave is the engine.
interface dct_coef_engine_if #(
   parameter int unsigned PIX_W = 9,
   parameter int unsigned ACC_W = 32
);
   logic                    pix_valid;
   logic                    pix_ready;
   logic signed [PIX_W-1:0] pix_data;
   logic                    coef_valid;
   logic                    coef_ready;
   logic signed [ACC_W-1:0] coef_data;

   modport master (
      output pix_valid, pix_data, coef_ready,
      input  pix_ready, coef_valid, coef_data
   );

   modport slave (
      input  pix_valid, pix_data, coef_ready,
      output pix_ready, coef_valid, coef_data
   );
endinterface

// File: rtl/dct_cos_rom.sv
// Registered cosine-weight ROM addressed by {k1, k2, n1, n2}; one-cycle read latency.
// Every entry is a constant computed by cos_weight during elaboration.
module dct_cos_rom
   import dct_pkg::*;
#(
   parameter int unsigned N        = 8,
   parameter int unsigned COS_FRAC = 8,
   parameter int unsigned COS_W    = 32
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [4*idx_w(N)-1:0]        addr,
   output logic signed [COS_W-1:0]      data
);
   localparam int unsigned DEPTH = N * N * N * N;

   logic signed [COS_W-1:0] rom [DEPTH];

   for (genvar a = 0; a < DEPTH; a++) begin : g_rom
      assign rom[a] = COS_W'(cos_weight(int'(N), int'(COS_FRAC),
                                        int'((a / (N * N * N)) % N),
                                        int'((a / (N * N)) % N),
                                        int'((a / N) % N),
                                        int'(a % N)));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) data <= '0;
      else        data <= rom[addr];
   end
endmodule

// File: rtl/dct_coef_engine.sv
// Sequential 2D DCT coefficient engine: streams an N x N block and accumulates
// pixel * cos weight for a run-time selected (k1, k2); result is acc >>> COS_FRAC.
module dct_coef_engine
   import dct_pkg::*;
#(
   parameter int unsigned N        = 8,
   parameter int unsigned PIX_W    = 9,
   parameter int unsigned COS_FRAC = 8,
   parameter int unsigned COS_W    = 32,
   parameter int unsigned ACC_W    = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [idx_w(N)-1:0]     k1,
   input  logic [idx_w(N)-1:0]     k2,
   output logic                    busy,
   dct_coef_engine_if.slave        bus
);
   localparam int unsigned IW     = idx_w(N);
   localparam int unsigned PROD_W = PIX_W + COS_W;

   dct_state_e              state;
   logic [IW-1:0]           k1_q;
   logic [IW-1:0]           k2_q;
   logic [IW-1:0]           n1;
   logic [IW-1:0]           n2;
   logic signed [PIX_W-1:0] pix_q;
   logic signed [COS_W-1:0] w_q;
   logic                    mac_vld;
   logic signed [ACC_W-1:0] acc;
   logic signed [PROD_W-1:0] prod_c;
   logic                    accept_c;
   logic                    last_c;

   assign accept_c = bus.pix_valid & bus.pix_ready;
   assign last_c   = (n1 == IW'(N - 1)) && (n2 == IW'(N - 1));
   assign prod_c   = $signed(PROD_W'(pix_q)) * $signed(PROD_W'(w_q));

   // The ROM is read with the pre-increment counters, so w_q lines up with pix_q.
   dct_cos_rom #(
      .N        (N),
      .COS_FRAC (COS_FRAC),
      .COS_W    (COS_W)
   ) u_rom (
      .clk   (clk),
      .rst_n (rst_n),
      .addr  ({k1_q, k2_q, n1, n2}),
      .data  (w_q)
   );

   // FSM, counters, stage-1 pixel register, MAC and result hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         k1_q           <= '0;
         k2_q           <= '0;
         n1             <= '0;
         n2             <= '0;
         pix_q          <= '0;
         mac_vld        <= 1'b0;
         acc            <= '0;
         busy           <= 1'b0;
         bus.pix_ready  <= 1'b0;
         bus.coef_valid <= 1'b0;
         bus.coef_data  <= '0;
      end else begin
         mac_vld <= accept_c;
         if (accept_c) pix_q <= bus.pix_data;
         if (mac_vld)  acc   <= acc + ACC_W'(prod_c);

         unique case (state)
            IDLE: begin
               if (start) begin
                  k1_q          <= k1;
                  k2_q          <= k2;
                  n1            <= '0;
                  n2            <= '0;
                  acc           <= '0;
                  busy          <= 1'b1;
                  bus.pix_ready <= 1'b1;
                  state         <= ACCUM;
               end
            end
            ACCUM: begin
               if (accept_c) begin
                  n2 <= n2 + IW'(1);
                  if (n2 == IW'(N - 1)) n1 <= n1 + IW'(1);
                  if (last_c) begin
                     bus.pix_ready <= 1'b0;
                     state         <= DRAIN;
                  end
               end
            end
            DRAIN: state <= DONE;
            DONE: begin
               // First DONE edge captures the settled accumulator; later edges wait for the sink.
               if (!bus.coef_valid) begin
                  bus.coef_valid <= 1'b1;
                  bus.coef_data  <= acc >>> COS_FRAC;
               end else if (bus.coef_ready) begin
                  bus.coef_valid <= 1'b0;
                  busy           <= 1'b0;
                  state          <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dct_coef_engine.sv
// Directed bench for dct_coef_engine (N=8): hand-computed coefficients, handshake
// timing, stall/hold behaviour, mid-block reset and a cosine-weight sweep.
module tb_dct_coef_engine;
   localparam int unsigned N        = 8;
   localparam int unsigned PIX_W    = 9;
   localparam int unsigned COS_FRAC = 8;
   localparam int unsigned COS_W    = 32;
   localparam int unsigned ACC_W    = 32;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [2:0] k1    = '0;
   logic [2:0] k2    = '0;
   logic       busy;

   dct_coef_engine_if #(.PIX_W(PIX_W), .ACC_W(ACC_W)) bus ();

   dct_coef_engine #(
      .N(N), .PIX_W(PIX_W), .COS_FRAC(COS_FRAC), .COS_W(COS_W), .ACC_W(ACC_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .k1    (k1),
      .k2    (k2),
      .busy  (busy),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int px[64];
   time ts;
   time tv;
   logic signed [ACC_W-1:0] res;

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Independent golden weight: 256 * cos(row term) * cos(column term), truncated toward zero.
   function automatic int gold_w(input int a, input int b, input int r, input int c);
      real pi;
      real ca;
      real cb;
      pi = 3.14159265358979323846;
      ca = $cos($itor((2 * r + 1) * a) * pi / 16.0);
      cb = $cos($itor((2 * c + 1) * b) * pi / 16.0);
      return $rtoi(256.0 * ca * cb);
   endfunction

   task automatic fill(input int v);
      for (int i = 0; i < 64; i++) px[i] = v;
   endtask

   task automatic start_block(input int a, input int b);
      @(negedge clk);
      k1 = 3'(a); k2 = 3'(b); start = 1'b1;
      @(posedge clk);
      ts = $time;
      @(negedge clk);
      start = 1'b0; k1 = 3'(7 - a); k2 = 3'(5 + b);
      chk("start_busy", busy, 1);
      chk("start_ready", bus.pix_ready, 1);
   endtask

   task automatic feed(input int nbeats, input bit gaps, input bit poke);
      int idx = 0;
      int cyc = 0;
      while (idx < nbeats && cyc < 1000) begin
         bus.pix_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
         bus.pix_data  = PIX_W'(px[idx]);
         start         = poke && (idx == 10);
         if (bus.pix_valid && bus.pix_ready) idx++;
         @(negedge clk);
         cyc++;
      end
      bus.pix_valid = 1'b0;
      start         = 1'b0;
      chk("beats", idx, nbeats);
   endtask

   task automatic finish_block(input int hold, input bit poke, output logic signed [ACC_W-1:0] coef);
      int lat = 0;
      chk("drain_ready", bus.pix_ready, 0);
      while (bus.coef_valid !== 1'b1 && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      tv   = $time;
      coef = bus.coef_data;
      chk("latency", lat, 2);
      for (int i = 0; i < hold; i++) begin
         start = poke;
         @(negedge clk);
         chk("hold_valid", bus.coef_valid, 1);
         chk("hold_data", bus.coef_data, coef);
      end
      bus.coef_ready = 1'b1;
      start          = poke;
      @(negedge clk);
      bus.coef_ready = 1'b0;
      start          = 1'b0;
      chk("idle_busy", busy, 0);
      chk("idle_valid", bus.coef_valid, 0);
   endtask

   task automatic run_block(input int a, input int b, input bit gaps, input int hold, input bit poke,
                            output logic signed [ACC_W-1:0] coef);
      start_block(a, b);
      feed(64, gaps, poke);
      finish_block(hold, poke, coef);
   endtask

   initial begin
      bus.pix_valid  = 1'b0;
      bus.pix_data   = '0;
      bus.coef_ready = 1'b0;

      // Reset state
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_ready", bus.pix_ready, 0);
      chk("rst_valid", bus.coef_valid, 0);
      chk("rst_data", bus.coef_data, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // DC of a flat block: 64 * 100 * 256 = 1638400 -> 6400, valid after s+66
      fill(100);
      run_block(0, 0, 1'b0, 0, 1'b0, res);
      chk("dc_flat", res, 6400);
      chk("dc_flat_time", tv - ts, 665);

      // Row 0 = 10 with k1=3: 8 * 10 * 212 = 16960 -> 66
      fill(0);
      for (int i = 0; i < 8; i++) px[i] = 10;
      run_block(3, 0, 1'b0, 0, 1'b0, res);
      chk("row0_k3", res, 66);

      // Single pixel (1,0) = 1 with k1=3: acc = -49 floors to -1
      fill(0);
      px[8] = 1;
      run_block(3, 0, 1'b0, 0, 1'b0, res);
      chk("floor_neg", res, -1);

      // All -1 at DC: -16384 >>> 8 = -64
      fill(-1);
      run_block(0, 0, 1'b0, 0, 1'b0, res);
      chk("dc_neg", res, -64);

      // Pixel (2,5) = -256 with k1=3,k2=0: weight -251 -> 251
      fill(0);
      px[21] = -256;
      run_block(3, 0, 1'b0, 0, 1'b0, res);
      chk("impulse_k3", res, 251);

      // Random stalls, held-off sink and ignored start pulses give the full-rate answer
      fill(100);
      run_block(0, 0, 1'b1, 5, 1'b1, res);
      chk("dc_stall", res, 6400);

      // Reset mid-block, then a clean all-ones DC block
      fill(7);
      start_block(5, 2);
      feed(30, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_ready", bus.pix_ready, 0);
      chk("mid_rst_valid", bus.coef_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      fill(1);
      run_block(0, 0, 1'b0, 0, 1'b0, res);
      chk("after_rst", res, 64);

      // Weight sweep: a -256 impulse returns exactly the negated weight
      for (int a = 0; a < 8; a++) begin
         for (int b = 0; b < 8; b++) begin
            for (int j = 0; j < 8; j++) begin
               int r;
               int c;
               r = j;
               c = (3 * j + a + b) % 8;
               fill(0);
               px[r * 8 + c] = -256;
               run_block(a, b, 1'b0, 0, 1'b0, res);
               chk($sformatf("sweep k%0d%0d n%0d%0d", a, b, r, c), res, -gold_w(a, b, r, c));
            end
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end
endmodule
